// File: rtl/eth_fcs_pkg.sv
// rtl/eth_fcs_pkg.sv - shared CRC-32 constants and FSM state type for the Ethernet FCS checker
package eth_fcs_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam int unsigned  LEN_CNT_W   = 11;
    localparam logic [10:0]  LEN_CNT_MAX = 11'h7FF;
    localparam logic [10:0]  FILL_LAST   = 11'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PASS = 2'd2
    } fcs_state_e;

endpackage

// File: rtl/crc32_refl_d8_step.sv
// rtl/crc32_refl_d8_step.sv - one-byte combinational step of reflected CRC-32, LSB first, no final XOR
module crc32_refl_d8_step
    import eth_fcs_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// rtl/eth_rx_fcs_check.sv - recomputes CRC-32 over each RX frame, strips the 4 FCS bytes and issues a verdict
module eth_rx_fcs_check
    import eth_fcs_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic       crc_err,
    output logic       len_err
);

    fcs_state_e          state;
    logic [31:0]         crc;
    logic [31:0]         crc_seed;
    logic [31:0]         crc_next;
    logic [LEN_CNT_W-1:0] cnt;
    logic [LEN_CNT_W-1:0] cnt_next;
    logic [3:0][7:0]     dly;
    logic                crc_bad;
    logic                len_bad;

    // The register already holds INIT in IDLE; the explicit seed keeps byte 0 correct regardless.
    assign crc_seed = (state == IDLE) ? CRC32_INIT : crc;

    crc32_refl_d8_step u_crc_step (
        .crc_in  (crc_seed),
        .data    (in_data),
        .crc_out (crc_next)
    );

    assign cnt_next = (cnt == LEN_CNT_MAX) ? cnt : cnt + 1'b1;
    assign crc_bad  = (crc_next != CRC32_RESIDUE);
    assign len_bad  = (int'(cnt_next) < MIN_LEN) || (int'(cnt_next) > MAX_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            crc        <= CRC32_INIT;
            cnt        <= '0;
            dly        <= '0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            if (in_valid) begin
                dly <= {dly[2:0], in_data};
                // In PASS the oldest delay-line byte is exactly four beats behind the input.
                if (state == PASS) begin
                    out_valid <= 1'b1;
                    out_data  <= dly[3];
                    out_last  <= in_last;
                end
                if (in_last) begin
                    state      <= IDLE;
                    crc        <= CRC32_INIT;
                    cnt        <= '0;
                    frame_done <= 1'b1;
                    crc_err    <= crc_bad;
                    len_err    <= len_bad;
                    frame_ok   <= !crc_bad && !len_bad;
                end else begin
                    crc <= crc_next;
                    cnt <= cnt_next;
                    case (state)
                        IDLE:    state <= FILL;
                        FILL:    state <= (cnt == FILL_LAST) ? PASS : FILL;
                        PASS:    state <= PASS;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// tb/tb_eth_rx_fcs_check.sv - randomized self-checking bench for eth_rx_fcs_check against a frame-level model
module tb_eth_rx_fcs_check;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, out_last, frame_done, frame_ok, crc_err, len_err;

    eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .crc_err    (crc_err),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx [0:2047];
    int         tx_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] crc_tx(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_byte(c, tx[i]);
        return c;
    endfunction

    task automatic add_fcs(input int n);
        logic [31:0] f;
        f = ~crc_tx(n);
        tx[n]   = f[7:0];
        tx[n+1] = f[15:8];
        tx[n+2] = f[23:16];
        tx[n+3] = f[31:24];
        tx_n = n + 4;
    endtask

    task automatic build_arp();
        logic [8*42-1:0] h;
        h = 336'hffffffffffff_020000000001_0806_0001_0800_0604_0001_020000000001_c0a8010a_000000000000_c0a80101;
        for (int i = 0; i < 60; i++) tx[i] = (i < 42) ? h[8*(41-i) +: 8] : 8'h00;
        add_fcs(60);
    endtask

    task automatic build_random(input int payload);
        for (int i = 0; i < payload; i++) tx[i] = 8'($urandom);
        add_fcs(payload);
    endtask

    // Frame-level model: bytes seen so far, payload emitted four beats late, verdict from the residue.
    logic [7:0] mq[$];
    logic       exp_valid = 0, exp_last = 0, exp_done = 0, exp_ok = 0, exp_crc = 0, exp_len = 0;
    logic       exp_data_chk = 0, exp_rst = 0;
    logic [7:0] exp_data = 0;

    always @(posedge clk) begin : model
        logic [31:0] c;
        int          k;
        int          n;
        exp_valid    <= 1'b0;
        exp_last     <= 1'b0;
        exp_done     <= 1'b0;
        exp_ok       <= 1'b0;
        exp_crc      <= 1'b0;
        exp_len      <= 1'b0;
        exp_data_chk <= 1'b0;
        exp_rst      <= rst;
        if (rst) begin
            mq.delete();
            exp_data     <= 8'h00;
            exp_data_chk <= 1'b1;
        end else if (in_valid) begin
            mq.push_back(in_data);
            k = mq.size() - 1;
            if (k >= 4) begin
                exp_valid    <= 1'b1;
                exp_data     <= mq[k-4];
                exp_last     <= in_last;
                exp_data_chk <= 1'b1;
            end
            if (in_last) begin
                n = mq.size();
                c = 32'hFFFFFFFF;
                foreach (mq[i]) c = crc_byte(c, mq[i]);
                exp_done <= 1'b1;
                exp_crc  <= (c != 32'hDEBB20E3);
                exp_len  <= (n < 64) || (n > 1518);
                exp_ok   <= (c == 32'hDEBB20E3) && (n >= 64) && (n <= 1518);
                mq.delete();
            end
        end
    end

    int   beats = 0, last_beats = 0, done_cnt = 0, ok_cnt = 0;
    logic last_ok = 0, last_crc = 0, last_len = 0;

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_data_chk) chk("out_data", 32'(out_data), 32'(exp_data));
        if (exp_valid) chk("out_last", 32'(out_last), 32'(exp_last));
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("frame_ok", 32'(frame_ok), 32'(exp_ok));
        chk("crc_err", 32'(crc_err), 32'(exp_crc));
        chk("len_err", 32'(len_err), 32'(exp_len));
        if (exp_rst) begin
            beats = 0;
        end else begin
            if (out_valid) beats++;
            if (frame_done) begin
                done_cnt++;
                if (frame_ok) ok_cnt++;
                last_beats = beats;
                beats      = 0;
                last_ok    = frame_ok;
                last_crc   = crc_err;
                last_len   = len_err;
            end
        end
    end

    task automatic beat(input logic v, input logic [7:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 8'($urandom), 1'b0);
    endtask

    // No gap before byte 0, so consecutive calls give back-to-back frames.
    task automatic send(input int gap_pct);
        for (int i = 0; i < tx_n; i++) begin
            while (i > 0 && $urandom_range(99) < gap_pct) beat(1'b0, 8'($urandom), 1'b0);
            beat(1'b1, tx[i], i == tx_n - 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic verdict(input string name, input int d0, input int nbeats,
                           input logic ok, input logic ce, input logic le);
        chk({name, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_beats"}, 32'(last_beats), 32'(nbeats));
        chk({name, "_ok"}, 32'(last_ok), 32'(ok));
        chk({name, "_crc"}, 32'(last_crc), 32'(ce));
        chk({name, "_len"}, 32'(last_len), 32'(le));
    endtask

    initial begin
        int d0;
        int o0;
        int len;
        logic [7:0] s [0:8];
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 9; i++) s[i] = 8'h31 + 8'(i);
        for (int i = 0; i < 9; i++) tx[i] = s[i];
        chk("model_check_value", ~crc_tx(9), 32'hCBF43926);

        build_arp();
        d0 = done_cnt; send(0); idle(3);
        verdict("arp_good", d0, 60, 1'b1, 1'b0, 1'b0);

        tx[20] = tx[20] ^ 8'h01;
        d0 = done_cnt; send(0); idle(3);
        verdict("arp_bitflip", d0, 60, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) tx[i] = s[i];
        add_fcs(9);
        chk("fcs_bytes", {tx[9], tx[10], tx[11], tx[12]}, 32'h2639F4CB);
        d0 = done_cnt; send(0); idle(3);
        verdict("check_runt", d0, 9, 1'b0, 1'b0, 1'b1);

        tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03; tx_n = 3;
        d0 = done_cnt; send(0); idle(3);
        chk("short3_done", 32'(done_cnt - d0), 32'd1);
        chk("short3_beats", 32'(last_beats), 32'd0);
        chk("short3_len", 32'(last_len), 32'd1);

        tx[0] = 8'h5A; tx_n = 1;
        d0 = done_cnt; send(0); idle(3);
        chk("n1_done", 32'(done_cnt - d0), 32'd1);
        chk("n1_len", 32'(last_len), 32'd1);

        d0 = done_cnt; o0 = ok_cnt;
        build_random(60); send(30);
        build_random(60); send(30);
        idle(3);
        chk("b2b_done", 32'(done_cnt - d0), 32'd2);
        chk("b2b_ok", 32'(ok_cnt - o0), 32'd2);

        build_random(60);
        d0 = done_cnt;
        for (int i = 0; i < 30; i++) beat(1'b1, tx[i], 1'b0);
        rst = 1'b1;
        beat(1'b1, 8'hAA, 1'b0);
        beat(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        idle(2);
        chk("abort_no_verdict", 32'(done_cnt - d0), 32'd0);
        send(0); idle(3);
        verdict("after_reset", d0, 60, 1'b1, 1'b0, 1'b0);

        build_random(1514);
        d0 = done_cnt; send(0); idle(3);
        verdict("max_len", d0, 1514, 1'b1, 1'b0, 1'b0);
        build_random(1515);
        d0 = done_cnt; send(0); idle(3);
        verdict("over_max", d0, 1515, 1'b0, 1'b0, 1'b1);

        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(100, 1);
            if (len >= 5) begin
                build_random(len - 4);
                if ($urandom_range(1) == 1) begin
                    int p;
                    p = $urandom_range(len - 1);
                    tx[p] = tx[p] ^ (8'h01 << $urandom_range(7));
                end
            end else begin
                for (int i = 0; i < len; i++) tx[i] = 8'($urandom);
                tx_n = len;
            end
            send($urandom_range(40));
            if ($urandom_range(1) == 1) idle($urandom_range(3));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
